program_fetch_ctrl: RTL and testbench

PROGRAM_FETCH_CTRL -- requirements
Module: program_fetch_ctrl

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/program_fetch_ctrl_if.sv | 30 +++
 rtl/fetch_fifo2.sv | 71 +++++++
 rtl/program_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_program_fetch_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the program fetch controller: state encoding,
// PC increment, prefetch buffer depth and the redirect-target legality test.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

  localparam int PC_STEP    = 4;
  localparam int FIFO_DEPTH = 2;

  // A target is legal when word aligned and inside the program memory.
  function automatic logic is_legal_target(input logic [31:0] tgt, input int unsigned depth);
    return (tgt[1:0] == 2'b00) && ((tgt >> 2) < depth);
  endfunction

endpackage

// File: rtl/program_fetch_ctrl_if.sv
// Fetch controller bundle: start/redirect control, ROM port, instruction stream and status.
// master is the controller side, slave is the surrounding environment.
interface program_fetch_ctrl_if #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
);

  logic                            start_i;
  logic                            redirect_i;
  logic [31:0]                     redirect_pc_i;
  logic [$clog2(MEMORY_DEPTH)-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0]           rom_data_i;
  logic [DATA_WIDTH-1:0]           instr_o;
  logic [31:0]                     pc_o;
  logic                            instr_valid_o;
  logic                            instr_ready_i;
  logic                            busy_o;
  logic                            addr_err_o;

  modport master (
    input  start_i, redirect_i, redirect_pc_i, rom_data_i, instr_ready_i,
    output rom_addr_o, instr_o, pc_o, instr_valid_o, busy_o, addr_err_o
  );

  modport slave (
    output start_i, redirect_i, redirect_pc_i, rom_data_i, instr_ready_i,
    input  rom_addr_o, instr_o, pc_o, instr_valid_o, busy_o, addr_err_o
  );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, instr} buffer with flush; head is visible the cycle after a push.
// A push into a full buffer is accepted only together with a pop; flush beats push.
module fetch_fifo2
  import fetch_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == 2'(FIFO_DEPTH));
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;

endmodule

// File: rtl/program_fetch_ctrl.sv
// Prefetching fetch controller: start/redirect to first valid instruction is 2 cycles, 1 instr/cycle streaming.
// instr_ready_i low stalls issue once buffered plus in-flight reads reach two; outputs hold while stalled.
module program_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  program_fetch_ctrl_if.master bus
);

  localparam int AW = $clog2(MEMORY_DEPTH);

  typedef struct packed {
    logic [31:0]           pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ret_pc_q, ret_pc_d;
  logic         inflight_q, inflight_d;
  logic         kill_q, kill_d;
  logic         addr_err_q, addr_err_d;

  entry_t       fifo_head, fifo_in;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [1:0]   fifo_count;

  logic         ret_live, bypass, instr_valid, pop;
  logic         flush, redirect_ok, issue, last_word;
  logic [2:0]   occ_sum;

  // A returning read is shown straight from the ROM when the buffer is empty,
  // which is what makes the first instruction valid two cycles after start.
  always_comb begin
    ret_live       = inflight_q && !kill_q && (state_q != ST_ERROR);
    flush          = bus.redirect_i && ((state_q == ST_RUN) || (state_q == ST_DONE));
    redirect_ok    = flush && is_legal_target(bus.redirect_pc_i, MEMORY_DEPTH);
    bypass         = fifo_empty && ret_live;
    instr_valid    = !fifo_empty || ret_live;
    pop            = instr_valid && bus.instr_ready_i;
    fifo_pop       = pop && !fifo_empty;
    fifo_push      = ret_live && !(bypass && pop) && (!fifo_full || fifo_pop);
    fifo_in.pc     = ret_pc_q;
    fifo_in.instr  = bus.rom_data_i;
    occ_sum        = {1'b0, fifo_count} + {2'b00, ret_live};
    issue          = (state_q == ST_RUN) && (occ_sum < (3'(FIFO_DEPTH) + {2'b00, pop}));
    last_word      = (pc_q >> 2) == 32'(MEMORY_DEPTH - 1);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_err_d = addr_err_q;
    inflight_d = issue;
    kill_d     = issue && flush;
    ret_pc_d   = issue ? pc_q : ret_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_RUN, ST_DONE: begin
        if (flush && !redirect_ok) begin
          state_d    = ST_ERROR;
          addr_err_d = 1'b1;
        end else if (redirect_ok) begin
          state_d = ST_RUN;
          pc_d    = bus.redirect_pc_i;
        end else if (issue) begin
          pc_d = pc_q + 32'(PC_STEP);
          if (last_word) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ret_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_pc_q   <= ret_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      addr_err_q <= addr_err_d;
    end
  end

  fetch_fifo2 #(
    .W($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bus.rom_addr_o    = pc_q[AW+1:2];
  assign bus.instr_valid_o = instr_valid;
  assign bus.instr_o       = bypass ? bus.rom_data_i : fifo_head.instr;
  assign bus.pc_o          = bypass ? ret_pc_q : fifo_head.pc;
  assign bus.busy_o        = (state_q == ST_RUN) || ret_live || !fifo_empty;
  assign bus.addr_err_o    = addr_err_q;

endmodule

// File: tb/tb_program_fetch_ctrl.sv
// Bench for program_fetch_ctrl: registered-read ROM, queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_program_fetch_ctrl;

  localparam int          DEPTH    = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   model_on = 1'b0;

  program_fetch_ctrl_if #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  program_fetch_ctrl #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (DW),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] w);
    return 32'hC0DE_0000 | (w * 32'h0000_0101);
  endfunction

  // single-port program ROM with registered read
  always @(posedge clk) bus.rom_data_i <= rom_word(32'(bus.rom_addr_o));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of issued-but-unconsumed PCs; an entry becomes
  // visible the cycle after its read is issued.
  int          m_state;
  logic [31:0] m_pc;
  bit          m_err;
  logic [31:0] m_q[$];
  bit          m_v, m_pop, m_iss, m_fl, m_ok;

  always @(negedge clk) begin
    m_v = (m_q.size() > 0);
    if (model_on) begin
      check("valid", bus.instr_valid_o, m_v);
      check("busy", bus.busy_o, (m_state == M_RUN) || m_v);
      check("addr_err", bus.addr_err_o, m_err);
      check("rom_addr", bus.rom_addr_o, 5'(m_pc >> 2));
      if (m_v) begin
        check("pc", bus.pc_o, m_q[0]);
        check("instr", bus.instr_o, rom_word(m_q[0] >> 2));
      end
    end
    if (reset) begin
      m_state  = M_IDLE;
      m_pc     = RESET_PC;
      m_err    = 1'b0;
      m_q.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      m_pop = m_v && bus.instr_ready_i;
      m_iss = (m_state == M_RUN) && ((m_q.size() - int'(m_pop)) < 2);
      m_fl  = bus.redirect_i && ((m_state == M_RUN) || (m_state == M_DONE));
      m_ok  = m_fl && (bus.redirect_pc_i % 4 == 0) && (bus.redirect_pc_i / 4 < DEPTH);
      if (m_pop) void'(m_q.pop_front());
      if (m_fl) m_q.delete();
      if (m_state == M_IDLE) begin
        if (bus.start_i) begin
          m_state = M_RUN;
          m_pc    = RESET_PC;
        end
      end else if (m_fl && !m_ok) begin
        m_state = M_ERR;
        m_err   = 1'b1;
      end else if (m_ok) begin
        m_state = M_RUN;
        m_pc    = bus.redirect_pc_i;
      end else if (m_iss) begin
        m_q.push_back(m_pc);
        if (m_pc / 4 == DEPTH - 1) m_state = M_DONE;
        m_pc = m_pc + 4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_pc(input string name, input logic [31:0] pc);
    @(negedge clk);
    check({name, "_valid"}, bus.instr_valid_o, 1'b1);
    check({name, "_pc"}, bus.pc_o, pc);
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    finish_run();
  end

  initial begin
    reset             = 1'b1;
    bus.start_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.instr_ready_i = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", bus.instr_valid_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_err", bus.addr_err_o, 1'b0);
    check("rst_rom_addr", bus.rom_addr_o, 5'd0);
    check("rst_instr", bus.instr_o, 32'h0);

    // streaming to DONE
    tick(); bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    @(negedge clk);
    check("stream_first_addr", bus.rom_addr_o, 5'd0);
    tick(); expect_pc("stream_c2", 32'h0);
    check("stream_c2_instr", bus.instr_o, 32'hC0DE_0000);
    tick(); expect_pc("stream_c3", 32'h4);
    repeat (40) tick();
    @(negedge clk);
    check("done_busy", bus.busy_o, 1'b0);
    check("done_valid", bus.instr_valid_o, 1'b0);
    tick(); bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    @(negedge clk);
    check("done_ignores_start", bus.busy_o, 1'b0);

    // backpressure
    tick(); do_reset();
    bus.start_i = 1'b1; bus.instr_ready_i = 1'b0;
    tick(); bus.start_i = 1'b0;
    repeat (5) tick();
    expect_pc("bp_hold", 32'h0);
    check("bp_no_more_reads", bus.rom_addr_o, 5'd2);
    tick(); bus.instr_ready_i = 1'b1;
    expect_pc("bp_rel0", 32'h0);
    tick(); expect_pc("bp_rel1", 32'h4);
    tick(); expect_pc("bp_rel2", 32'h8);

    // legal redirect, then illegal unaligned redirect
    tick(); do_reset();
    bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    repeat (3) tick();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40;
    expect_pc("redir_n", 32'h8);
    tick(); bus.redirect_i = 1'b0;
    @(negedge clk);
    check("redir_n1_valid", bus.instr_valid_o, 1'b0);
    tick(); expect_pc("redir_n2", 32'h40);
    check("redir_n2_instr", bus.instr_o, 32'hC0DE_1010);
    tick(); expect_pc("redir_n3", 32'h44);
    tick(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h82;
    tick(); bus.redirect_i = 1'b0;
    @(negedge clk);
    check("bad82_err", bus.addr_err_o, 1'b1);
    check("bad82_valid", bus.instr_valid_o, 1'b0);
    check("bad82_busy", bus.busy_o, 1'b0);
    tick(); bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("err_sticky", bus.addr_err_o, 1'b1);
    check("err_no_reads", bus.rom_addr_o, 5'd19);
    check("err_no_valid", bus.instr_valid_o, 1'b0);

    // out-of-range redirect
    tick(); do_reset();
    bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    repeat (2) tick();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h80;
    tick(); bus.redirect_i = 1'b0;
    @(negedge clk);
    check("bad80_err", bus.addr_err_o, 1'b1);
    check("bad80_valid", bus.instr_valid_o, 1'b0);

    // reset with entries buffered and a read returning
    tick(); do_reset();
    bus.start_i = 1'b1; bus.instr_ready_i = 1'b0;
    tick(); bus.start_i = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", bus.instr_valid_o, 1'b0);
    check("midrst_busy", bus.busy_o, 1'b0);
    check("midrst_err", bus.addr_err_o, 1'b0);
    check("midrst_rom_addr", bus.rom_addr_o, 5'd0);
    check("midrst_instr", bus.instr_o, 32'h0);
    bus.instr_ready_i = 1'b1;
    repeat (3) tick();
    bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    tick(); expect_pc("restart_c2", 32'h0);

    // redirect in the same cycle as issuing the last word; start during RUN
    repeat (30) tick();
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h10;
    @(negedge clk);
    check("last_word_addr", bus.rom_addr_o, 5'd31);
    tick(); bus.redirect_i = 1'b0;
    tick(); bus.start_i = 1'b1;
    expect_pc("edge_n2", 32'h10);
    check("edge_busy", bus.busy_o, 1'b1);
    tick(); bus.start_i = 1'b0;
    expect_pc("edge_n3", 32'h14);
    tick(); expect_pc("edge_n4", 32'h18);
    repeat (40) tick();
    @(negedge clk);
    check("edge_done_busy", bus.busy_o, 1'b0);

    tick();
    finish_run();
  end

endmodule
